// File: rtl/imem_load_pkg.sv
// rtl/imem_load_pkg.sv - shared constants and state encoding for the program-memory loader
//
// Purpose: state encoding (RUN=0 .. DONE=5), program-memory geometry shared by
// the fetch path and the loader, and byte/length widths used by the header parser.
// Optional build macro used by the top: IMEM_LOAD_TIMEOUT_EN.
package imem_load_pkg;

    localparam int IMEM_ADDR_W    = 14;
    localparam int IMEM_DATA_W    = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } load_state_e;

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - little-endian byte-to-word assembler
//
// Purpose: collects DATA_W/8 bytes into one word, first byte in the low lane.
// Ports:
//   clock, reset  : clock, asynchronous active-high reset
//   clear         : synchronous clear of byte index and partial word (wins over byte_valid)
//   byte_valid    : byte_in is taken this cycle
//   byte_in       : incoming byte
//   word_full     : combinational, high in the cycle the last byte of a word is taken
//   word          : assembled word (complete from the cycle after word_full)
module imem_word_packer
    import imem_load_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic              word_full,
    output logic [DATA_W-1:0] word
);

    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] word_q, word_d;

    // Shifting in from the top means that after NBYTES bytes the first byte
    // has arrived at bits [7:0], which is the little-endian packing we want.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear) begin
            idx_d  = '0;
            word_d = '0;
        end else if (byte_valid) begin
            word_d = {byte_in, word_q[DATA_W-1:8]};
            idx_d  = idx_q + 1'b1;
        end
    end

    assign word_full = byte_valid && !clear && (idx_q == LAST_IDX);
    assign word      = word_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - program-memory port owner: instruction fetch in run mode, UART bootloader in load mode
//
// Purpose: in RUN the memory port follows fetch_addr. A prog_start pulse enters
// load mode: a 16-bit big-endian word count header, then little-endian 32-bit
// words, each written one cycle after its last byte. The CPU is held via cpu_hold.
// Optional build macro: IMEM_LOAD_TIMEOUT_EN (idle-byte timeout in HDR0/HDR1/DATA).
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   prog_start            : one-cycle load request, honoured only in RUN
//   rx_valid, rx_byte     : received byte strobe and data
//   rx_ready              : a byte can be taken this cycle
//   fetch_addr            : word address from the fetch unit
//   mem_addr, mem_we,
//   mem_wdata             : program memory port
//   cpu_hold              : CPU held in reset while loading (registered)
//   load_done             : one-cycle pulse in DONE
//   load_err              : sticky error, cleared by the next accepted prog_start
//   word_cnt              : words written in the current or last load
module imem_load_ctrl
    import imem_load_pkg::*;
#(
    parameter int ADDR_W      = IMEM_ADDR_W,
    parameter int DATA_W      = IMEM_DATA_W,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              prog_start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W-1:0] word_cnt
);

    // Lengths are compared one bit wider than the header so that a full
    // 2^ADDR_W-word image is legal and anything above it is not.
    localparam logic [LEN_W:0] LEN_MAX = (LEN_W+1)'(2 ** ADDR_W);

    load_state_e       state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic              load_err_q, load_err_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_done_q, load_done_d;

    logic              pack_clear;
    logic              pack_valid;
    logic              pack_full;
    logic [DATA_W-1:0] pack_word;
    logic [LEN_W-1:0]  hdr_len;
    logic [LEN_W:0]    cnt_plus1;

`ifdef IMEM_LOAD_TIMEOUT_EN
    logic [31:0]       idle_q, idle_d;
`else
    logic              unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    assign pack_valid = rx_valid && (state_q == ST_DATA);
    assign hdr_len    = {len_q[LEN_W-1:8], rx_byte};
    // Pre-increment compare: with a 2^ADDR_W image the counter wraps to 0 on
    // the final write, so the wider sum is what detects the last word.
    assign cnt_plus1  = (LEN_W+1)'(word_cnt_q) + 1'b1;

    imem_word_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (pack_clear),
        .byte_valid (pack_valid),
        .byte_in    (rx_byte),
        .word_full  (pack_full),
        .word       (pack_word)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        load_err_d = load_err_q;
        rx_ready   = 1'b0;
        mem_addr   = word_cnt_q;
        mem_we     = 1'b0;
        pack_clear = 1'b0;
`ifdef IMEM_LOAD_TIMEOUT_EN
        idle_d     = '0;
`endif

        case (state_q)
            ST_RUN: begin
                mem_addr = fetch_addr;
                if (prog_start) begin
                    state_d    = ST_HDR0;
                    load_err_d = 1'b0;
                    word_cnt_d = '0;
                    pack_clear = 1'b1;
                end
            end
            ST_HDR0: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    len_d[LEN_W-1:8] = rx_byte;
                    state_d          = ST_HDR1;
                end
            end
            ST_HDR1: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    len_d = hdr_len;
                    if (hdr_len == '0) begin
                        state_d = ST_DONE;
                    end else if ({1'b0, hdr_len} > LEN_MAX) begin
                        load_err_d = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                rx_ready = 1'b1;
                if (pack_full) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_we     = 1'b1;
                word_cnt_d = word_cnt_q + 1'b1;
                // A byte arriving here has nowhere to go; drop it and flag it,
                // but keep loading so the remaining words still land.
                if (rx_valid) begin
                    load_err_d = 1'b1;
                end
                if (cnt_plus1 == {1'b0, len_q}) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

`ifdef IMEM_LOAD_TIMEOUT_EN
        // Counter is zero on entry to a waiting state (previous state was not
        // waiting) and after every byte, since rx_ready is high while waiting.
        if ((state_q == ST_HDR0) || (state_q == ST_HDR1) || (state_q == ST_DATA)) begin
            if (rx_valid) begin
                idle_d = '0;
            end else if (idle_q == 32'(TIMEOUT_CYC - 1)) begin
                state_d    = ST_RUN;
                load_err_d = 1'b1;
                pack_clear = 1'b1;
                idle_d     = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
`endif

        cpu_hold_d  = (state_d != ST_RUN);
        load_done_d = (state_d == ST_DONE);
    end

    assign mem_wdata = pack_word;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign word_cnt  = word_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            len_q       <= '0;
            word_cnt_q  <= '0;
            load_err_q  <= 1'b0;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            load_err_q  <= load_err_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
        end
    end

`ifdef IMEM_LOAD_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - directed self-checking bench for imem_load_ctrl
module tb_imem_load_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        prog_start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_ready;
    logic [13:0] fetch_addr = 14'h0;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [13:0] word_cnt;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  done_cnt = 0;
    int  done_base;

    imem_load_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .prog_start (prog_start),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_ready   (rx_ready),
        .fetch_addr (fetch_addr),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_cnt   (word_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every write must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            if (load_done === 1'b1) done_cnt++;
            if (mem_we !== 1'b0) begin
                check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("write_addr", 64'(mem_addr), 64'(w.addr));
                    check("write_data", 64'(mem_wdata), 64'(w.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        step();
        rx_valid = 1'b0;
        step();
    endtask

    task automatic pulse_start();
        prog_start = 1'b1;
        step();
        prog_start = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_load_err", 64'(load_err), 64'd0);
        check("rst_word_cnt", 64'(word_cnt), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        reset = 1'b0;
        step();

        // Run mode: address follows fetch, bytes ignored
        fetch_addr = 14'h0003;
        #1;
        check("run_mem_addr", 64'(mem_addr), 64'h3);
        check("run_rx_ready", 64'(rx_ready), 64'd0);
        send_byte(8'hAA);
        send_byte(8'h55);
        check("run_cpu_hold", 64'(cpu_hold), 64'd0);
        check("run_word_cnt", 64'(word_cnt), 64'd0);

        // Normal two-word load
        done_base = done_cnt;
        exp_q.push_back('{addr: 14'd0, data: 32'h12345678});
        exp_q.push_back('{addr: 14'd1, data: 32'hDEADBEEF});
        pulse_start();
        check("load_cpu_hold_rise", 64'(cpu_hold), 64'd1);
        check("load_rx_ready", 64'(rx_ready), 64'd1);
        check("load_mem_addr", 64'(mem_addr), 64'd0);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        check("load_done_pulse", 64'(load_done), 64'd1);
        check("load_hold_in_done", 64'(cpu_hold), 64'd1);
        check("load_word_cnt", 64'(word_cnt), 64'd2);
        step();
        check("load_done_low", 64'(load_done), 64'd0);
        check("load_hold_fall", 64'(cpu_hold), 64'd0);
        check("load_err_clean", 64'(load_err), 64'd0);
        check("load_done_once", 64'(done_cnt - done_base), 64'd1);
        check("load_back_to_fetch", 64'(mem_addr), 64'h3);

        // Zero length header
        done_base = done_cnt;
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
        check("zero_done_count", 64'(done_cnt - done_base), 64'd1);
        check("zero_err", 64'(load_err), 64'd0);
        check("zero_word_cnt", 64'(word_cnt), 64'd0);
        check("zero_hold", 64'(cpu_hold), 64'd0);

        // Length error 16385
        done_base = done_cnt;
        pulse_start();
        send_byte(8'h40); send_byte(8'h01);
        check("len_err_flag", 64'(load_err), 64'd1);
        check("len_err_hold", 64'(cpu_hold), 64'd0);
        check("len_err_no_done", 64'(done_cnt - done_base), 64'd0);
        step();
        check("len_err_sticky", 64'(load_err), 64'd1);
        pulse_start();
        check("len_err_cleared", 64'(load_err), 64'd0);

        // Overrun during WRITE (already in HDR0)
        done_base = done_cnt;
        exp_q.push_back('{addr: 14'd0, data: 32'h04030201});
        exp_q.push_back('{addr: 14'd1, data: 32'h0C0B0A09});
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        rx_valid = 1'b1;
        rx_byte  = 8'h04;
        step();
        rx_byte = 8'hFF;
        check("ovr_rx_ready_write", 64'(rx_ready), 64'd0);
        check("ovr_mem_we", 64'(mem_we), 64'd1);
        step();
        rx_valid = 1'b0;
        check("ovr_err_set", 64'(load_err), 64'd1);
        check("ovr_word_cnt1", 64'(word_cnt), 64'd1);
        step();
        send_byte(8'h09); send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
        step();
        check("ovr_word_cnt2", 64'(word_cnt), 64'd2);
        check("ovr_err_kept", 64'(load_err), 64'd1);
        check("ovr_done", 64'(done_cnt - done_base), 64'd1);

        // Async reset mid-DATA
        pulse_start();
        check("rst_mid_err_clear", 64'(load_err), 64'd0);
        exp_q.push_back('{addr: 14'd0, data: 32'hCAFEF00D});
        send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
        check("rst_mid_cnt_before", 64'(word_cnt), 64'd1);
        send_byte(8'h55); send_byte(8'h66);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_hold", 64'(cpu_hold), 64'd0);
        check("rst_mid_cnt", 64'(word_cnt), 64'd0);
        check("rst_mid_mem_addr", 64'(mem_addr), 64'h3);
        check("rst_mid_we", 64'(mem_we), 64'd0);
        step();
        reset = 1'b0;
        step();

        // Fresh load after reset: packer must restart at byte 0
        done_base = done_cnt;
        exp_q.push_back('{addr: 14'd0, data: 32'h44332211});
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        step();
        check("post_rst_cnt", 64'(word_cnt), 64'd1);
        check("post_rst_done", 64'(done_cnt - done_base), 64'd1);

        // Maximum legal length 16384 is accepted
        pulse_start();
        send_byte(8'h40); send_byte(8'h00);
        check("max_len_err", 64'(load_err), 64'd0);
        check("max_len_hold", 64'(cpu_hold), 64'd1);
        check("max_len_ready", 64'(rx_ready), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("max_len_abort_hold", 64'(cpu_hold), 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Owns the single port of the program ROM/RAM (14-bit word address, 32-bit data).
- In run mode, the port is given to the instruction-fetch unit.
- In load mode, the port is given to a UART byte-stream bootloader, and the CPU is held in reset via cpu_hold.
- Assembles received bytes into words, sequences the writes, and reports completion or error.

Parameters:
ADDR_W, 14, word-address width of program memory (depth = 2^ADDR_W)
DATA_W, 32, instruction word width (fixed at 4 bytes)
TIMEOUT_CYC, 1000000, max idle cycles between bytes in load mode (used only with the optional feature)

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
prog_start  input  1  one-cycle request to enter load mode
rx_valid  input  1  one-cycle strobe: rx_byte is valid
rx_byte  input  8  received UART byte
rx_ready  output  1  controller can accept a byte this cycle
fetch_addr  input  ADDR_W  word address from the fetch unit (PC[15:2])
mem_addr  output  ADDR_W  address to program memory
mem_we  output  1  program memory write enable
mem_wdata  output  DATA_W  program memory write data
cpu_hold  output  1  holds the fetch unit/CPU in reset while loading
load_done  output  1  one-cycle pulse: load completed successfully
load_err  output  1  sticky error flag; cleared on the next accepted prog_start
word_cnt  output  ADDR_W  words written in the current or last load

Behaviour:
- Reset (async): state=RUN; mem_we=0, cpu_hold=0, load_done=0, load_err=0, word_cnt=0; byte index=0; word length register=0.
- Reset asserted mid-load: return to RUN immediately. Memory already written is kept, not rolled back.
- States: RUN, HDR0, HDR1, DATA, WRITE, DONE.
- RUN:
  - mem_addr=fetch_addr (combinational), mem_we=0, cpu_hold=0, rx_ready=0.
  - rx bytes are ignored.
  - prog_start=1 -> HDR0 next cycle; clear load_err and word_cnt.
- All states other than RUN: cpu_hold=1, registered. It rises the cycle after prog_start is sampled.
- prog_start is ignored outside RUN.
- HDR0: rx_ready=1. Byte received -> len[15:8] is stored; go to HDR1.
- HDR1: rx_ready=1. Byte received -> len[7:0] is stored, then:
  - len==0 -> DONE.
  - len>2^ADDR_W -> set load_err; go to RUN.
  - otherwise -> DATA.
- DATA:
  - rx_ready=1; bytes are packed little-endian. Byte k (0..3) goes to wdata[8k+7:8k].
  - After the 4th byte -> WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=word_cnt, mem_wdata=assembled word.
  - rx_ready=0.
  - word_cnt increments at the end of the cycle.
  - Next state: DONE if word_cnt+1==len, else DATA.
- Write latency: the write occurs the cycle after the 4th byte is sampled.
- In every load state except WRITE, mem_addr=word_cnt and mem_we=0.
- Overrun: rx_valid=1 while rx_ready=0 in any load state (i.e. WRITE):
  - the byte is dropped and load_err is set;
  - the load continues, because the count is still honoured from later bytes.
- DONE:
  - load_done=1 for one cycle; cpu_hold stays 1 during DONE;
  - next state RUN, so cpu_hold falls one cycle after load_done.
- Wrap-around: word_cnt never exceeds len, because len is checked in HDR1. With len==2^ADDR_W, word_cnt wraps to 0 on the final write; the DONE decision uses the pre-increment compare.
- load_err persists through RUN until the next prog_start.

Optional Feature:
- Macro: IMEM_LOAD_TIMEOUT_EN.
- Defined:
  - A 32-bit idle counter runs in HDR0/HDR1/DATA. It resets on every accepted byte and on state entry.
  - Reaching TIMEOUT_CYC -> set load_err, drop the partial word, go to RUN (cpu_hold released).
- Undefined:
  - No counter exists; the controller waits indefinitely for bytes.

Decomposition:
- Shared package imem_load_pkg:
  - state encoding constants (RUN=0 .. DONE=5);
  - IMEM_ADDR_W=14 and IMEM_DATA_W=32, reused by fetch and loader;
  - BYTES_PER_WORD=4.
- One natural sub-module, imem_word_packer: byte index counter plus 32-bit shift/assemble register. Outputs word_full and word; has a clear input.
- The FSM, mux and counters stay in the top.

Test Plan:
- Run mode: reset, then fetch_addr=0x0003 -> mem_addr=0x0003, mem_we=0, cpu_hold=0; rx bytes produce no writes.
- Normal load: prog_start, then bytes 00 02 | 78 56 34 12 | EF BE AD DE -> writes 0x12345678@0 and 0xDEADBEEF@1; load_done pulses once; word_cnt=2; cpu_hold falls the cycle after load_done.
- Zero length: header 00 00 -> DONE directly, no mem_we, load_done=1, load_err=0.
- Length error: header 40 01 (16385 > 16384) -> load_err=1, back to RUN, no writes; the next prog_start clears load_err.
- Overrun and async reset: rx_valid asserted during the WRITE cycle -> load_err=1, byte dropped. Asserting reset mid-DATA -> RUN immediately, cpu_hold=0, word_cnt=0.
- With IMEM_LOAD_TIMEOUT_EN and TIMEOUT_CYC=16: stop after 2 data bytes -> load_err=1 at idle cycle 16, state RUN, no partial write.
